wolfram_ca_engine: RTL and testbench

WOLFRAM_CA_ENGINE -- requirements
Module: wolfram_ca_engine

---
 rtl/wolfram_ca_pkg.sv | 13 +
 rtl/wolfram_ca_cell.sv | 12 +
 rtl/wolfram_ca_engine.sv | 124 ++++++++++++
 tb/tb_wolfram_ca_engine.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/wolfram_ca_pkg.sv
// Shared types and constants for the Wolfram elementary cellular automaton engine.
package wolfram_ca_pkg;

    localparam int RULE_W = 8;
    localparam int NBHD_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ca_state_e;

endpackage

// File: rtl/wolfram_ca_cell.sv
// Single-cell rule lookup: the 3-bit neighbourhood selects one bit of the rule number.
module wolfram_ca_cell
    import wolfram_ca_pkg::*;
(
    input  logic [NBHD_W-1:0] i_nbhd,
    input  logic [RULE_W-1:0] i_rule,
    output logic              o_next
);

    assign o_next = i_rule[i_nbhd];

endmodule

// File: rtl/wolfram_ca_engine.sv
// Load/run/drain engine that advances a 1-D elementary CA one generation per clock.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a load; cells_o/gen_o keep the last result
// RUN     | one generation per cycle until remaining reaches zero
// DONE    | result held on cells_o/gen_o until out_ready_i
module wolfram_ca_engine
    import wolfram_ca_pkg::*;
#(
    parameter int N_CELLS = 16,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [RULE_W-1:0]  rule_i,
    input  logic               wrap_i,
    input  logic [CNT_W-1:0]   steps_i,
    input  logic [N_CELLS-1:0] load_data_i,
    input  logic               load_valid_i,
    output logic               load_ready_o,
    input  logic               abort_i,
    output logic [N_CELLS-1:0] cells_o,
    output logic [CNT_W-1:0]   gen_o,
    output logic               busy_o,
    output logic               out_valid_o,
    input  logic               out_ready_i
);

    ca_state_e          r_state, w_state_nxt;
    logic [N_CELLS-1:0] r_cells, w_cells_nxt;
    logic [CNT_W-1:0]   r_gen, w_gen_nxt;
    logic [CNT_W-1:0]   r_remaining, w_remaining_nxt;
    logic [RULE_W-1:0]  r_rule, w_rule_nxt;
    logic               r_wrap, w_wrap_nxt;
    logic [N_CELLS-1:0] w_next_gen;
    logic [N_CELLS-1:0] w_left;
    logic [N_CELLS-1:0] w_right;

    // L comes from the higher-index neighbour, R from the lower-index one.
    for (genvar gi = 0; gi < N_CELLS; gi++) begin : g_cell
        if (gi == N_CELLS - 1) begin : g_top
            assign w_left[gi] = r_wrap & r_cells[0];
        end else begin : g_mid_l
            assign w_left[gi] = r_cells[gi+1];
        end
        if (gi == 0) begin : g_bot
            assign w_right[gi] = r_wrap & r_cells[N_CELLS-1];
        end else begin : g_mid_r
            assign w_right[gi] = r_cells[gi-1];
        end

        wolfram_ca_cell u_cell (
            .i_nbhd ({w_left[gi], r_cells[gi], w_right[gi]}),
            .i_rule (r_rule),
            .o_next (w_next_gen[gi])
        );
    end

    assign load_ready_o = (r_state == ST_IDLE) && !abort_i;
    assign busy_o       = (r_state == ST_RUN);
    assign out_valid_o  = (r_state == ST_DONE);
    assign cells_o      = r_cells;
    assign gen_o        = r_gen;

    always_comb begin
        w_state_nxt     = r_state;
        w_cells_nxt     = r_cells;
        w_gen_nxt       = r_gen;
        w_remaining_nxt = r_remaining;
        w_rule_nxt      = r_rule;
        w_wrap_nxt      = r_wrap;
        if (abort_i) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (load_valid_i) begin
                        w_state_nxt     = ST_RUN;
                        w_cells_nxt     = load_data_i;
                        w_rule_nxt      = rule_i;
                        w_wrap_nxt      = wrap_i;
                        w_remaining_nxt = steps_i;
                        w_gen_nxt       = '0;
                    end
                end
                ST_RUN: begin
                    if (r_remaining != '0) begin
                        w_cells_nxt     = w_next_gen;
                        w_remaining_nxt = r_remaining - 1'b1;
                        w_gen_nxt       = r_gen + 1'b1;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready_i) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cells     <= '0;
            r_gen       <= '0;
            r_remaining <= '0;
            r_rule      <= '0;
            r_wrap      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cells     <= w_cells_nxt;
            r_gen       <= w_gen_nxt;
            r_remaining <= w_remaining_nxt;
            r_rule      <= w_rule_nxt;
            r_wrap      <= w_wrap_nxt;
        end
    end

endmodule

// File: tb/tb_wolfram_ca_engine.sv
// Self-checking bench: directed cases plus random jobs against an arithmetic CA model.
module tb_wolfram_ca_engine;

    localparam int NC  = 8;
    localparam int CW  = 8;
    localparam int BUDGET = 300;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rule_i = '0;
    logic          wrap_i = 1'b0;
    logic [CW-1:0] steps_i = '0;
    logic [NC-1:0] load_data_i = '0;
    logic          load_valid_i = 1'b0;
    logic          load_ready_o;
    logic          abort_i = 1'b0;
    logic [NC-1:0] cells_o;
    logic [CW-1:0] gen_o;
    logic          busy_o;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    wolfram_ca_engine #(.N_CELLS(NC), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rule_i       (rule_i),
        .wrap_i       (wrap_i),
        .steps_i      (steps_i),
        .load_data_i  (load_data_i),
        .load_valid_i (load_valid_i),
        .load_ready_o (load_ready_o),
        .abort_i      (abort_i),
        .cells_o      (cells_o),
        .gen_o        (gen_o),
        .busy_o       (busy_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Next generation from the textbook definition: bit p of the rule, p = 4L+2C+R.
    function automatic logic [NC-1:0] ref_step(input logic [NC-1:0] c, input logic [7:0] rule,
                                               input bit wrap);
        logic [NC-1:0] nx;
        for (int i = 0; i < NC; i++) begin
            int l, r, p;
            l = (i == NC - 1) ? (wrap ? int'(c[0]) : 0) : int'(c[(i + 1) % NC]);
            r = (i == 0) ? (wrap ? int'(c[NC-1]) : 0) : int'(c[(i + NC - 1) % NC]);
            p = 4 * l + 2 * int'(c[i]) + r;
            nx[i] = (int'(rule) >> p) & 1;
        end
        return nx;
    endfunction

    function automatic logic [NC-1:0] ref_run(input logic [NC-1:0] seed, input logic [7:0] rule,
                                              input bit wrap, input int steps);
        logic [NC-1:0] c;
        c = seed;
        for (int k = 0; k < steps; k++) c = ref_step(c, rule, wrap);
        return c;
    endfunction

    // Loads one job, waits for DONE and checks latency and result; leaves the engine in DONE.
    task automatic run_job(input logic [NC-1:0] seed, input logic [7:0] rule, input bit wrap,
                           input int steps, input bit junk, input string tag);
        int cnt;
        @(posedge clk); #1;
        rule_i = rule; wrap_i = wrap; steps_i = CW'(steps);
        load_data_i = seed; load_valid_i = 1'b1;
        check({tag, " load_ready"}, 32'(load_ready_o), 32'd1);
        @(posedge clk); #1;
        load_valid_i = 1'b0;
        rule_i = 8'($urandom); wrap_i = 1'($urandom); steps_i = CW'($urandom);
        check({tag, " busy"}, 32'(busy_o), 32'd1);
        cnt = 0;
        while (!out_valid_o && cnt < BUDGET) begin
            if (junk) begin
                load_valid_i = 1'($urandom);
                load_data_i  = NC'($urandom);
            end
            @(posedge clk); #1;
            cnt++;
        end
        load_valid_i = 1'b0;
        check({tag, " latency"}, 32'(cnt), 32'(steps + 1));
        check({tag, " cells"}, 32'(cells_o), 32'(ref_run(seed, rule, wrap, steps)));
        check({tag, " gen"}, 32'(gen_o), 32'(steps));
    endtask

    task automatic release_done(input string tag);
        logic [NC-1:0] c;
        logic [CW-1:0] g;
        c = cells_o; g = gen_o;
        out_ready_i = 1'b1;
        @(posedge clk); #1;
        out_ready_i = 1'b0;
        check({tag, " idle valid"}, 32'(out_valid_o), 32'd0);
        check({tag, " idle ready"}, 32'(load_ready_o), 32'd1);
        check({tag, " kept"}, {8'(c), 8'(g)}, {8'(cells_o), 8'(gen_o)});
    endtask

    initial begin
        logic [NC-1:0] c_hold;
        logic [CW-1:0] g_hold;
        logic [NC-1:0] seed;
        bit            saw_valid;

        #12;
        check("rst cells", 32'(cells_o), 32'd0);
        check("rst gen", 32'(gen_o), 32'd0);
        check("rst busy", 32'(busy_o), 32'd0);
        check("rst valid", 32'(out_valid_o), 32'd0);
        check("rst ready", 32'(load_ready_o), 32'd1);
        #1 rst_n = 1'b1;

        run_job(8'h01, 8'h42, 1'b0, 1, 1'b0, "r42 s01");
        check("r42 s01 exact", 32'(cells_o), 32'h02);
        release_done("r42 s01");
        run_job(8'h80, 8'h42, 1'b1, 1, 1'b0, "r42 wrap");
        check("r42 wrap exact", 32'(cells_o), 32'h01);
        release_done("r42 wrap");
        run_job(8'h80, 8'h42, 1'b0, 1, 1'b0, "r42 null");
        check("r42 null exact", 32'(cells_o), 32'h00);
        release_done("r42 null");
        run_job(8'h10, 8'h5A, 1'b0, 1, 1'b0, "r5A s1");
        check("r5A s1 exact", 32'(cells_o), 32'h28);
        release_done("r5A s1");
        run_job(8'h10, 8'h5A, 1'b0, 0, 1'b0, "r5A s0");
        check("r5A s0 exact", 32'(cells_o), 32'h10);

        // DONE holds while the consumer stalls.
        c_hold = cells_o; g_hold = gen_o;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("hold cells", 32'(cells_o), 32'(c_hold));
            check("hold gen", 32'(gen_o), 32'(g_hold));
            check("hold valid", 32'(out_valid_o), 32'd1);
        end
        release_done("hold");

        // Abort on the 3rd RUN cycle: two generations have been computed.
        seed = 8'h5C;
        @(posedge clk); #1;
        rule_i = 8'd30; wrap_i = 1'b1; steps_i = 8'd10; load_data_i = seed; load_valid_i = 1'b1;
        @(posedge clk); #1;
        load_valid_i = 1'b0;
        saw_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            saw_valid |= out_valid_o;
        end
        abort_i = 1'b1;
        @(posedge clk); #1;
        abort_i = 1'b0;
        check("abort busy", 32'(busy_o), 32'd0);
        check("abort gen", 32'(gen_o), 32'd2);
        check("abort cells", 32'(cells_o), 32'(ref_run(seed, 8'd30, 1'b1, 2)));
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            saw_valid |= out_valid_o;
        end
        check("abort no valid", 32'(saw_valid), 32'd0);

        // Abort blocks a load presented in IDLE.
        abort_i = 1'b1; load_valid_i = 1'b1; load_data_i = 8'hA5; steps_i = 8'd1;
        #1 check("abort ready", 32'(load_ready_o), 32'd0);
        @(posedge clk); #1;
        abort_i = 1'b0; load_valid_i = 1'b0;
        check("abort noload busy", 32'(busy_o), 32'd0);
        check("abort noload cells", 32'(cells_o), 32'(ref_run(seed, 8'd30, 1'b1, 2)));

        // Random jobs with junk loads presented while busy.
        for (int j = 0; j < 25; j++) begin
            run_job(NC'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 12)),
                    1'b1, "rand");
            release_done("rand");
        end

        // Asynchronous reset in the middle of a run.
        @(posedge clk); #1;
        rule_i = 8'd110; wrap_i = 1'b0; steps_i = 8'd10; load_data_i = 8'hF1; load_valid_i = 1'b1;
        @(posedge clk); #1;
        load_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst cells", 32'(cells_o), 32'd0);
        check("arst gen", 32'(gen_o), 32'd0);
        check("arst busy", 32'(busy_o), 32'd0);
        check("arst valid", 32'(out_valid_o), 32'd0);
        check("arst ready", 32'(load_ready_o), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("arst stays idle", 32'(busy_o | out_valid_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
